li_expander: RTL and testbench

LI_EXPANDER -- requirements
Module: li_expander

---
 rtl/li_expander.sv | 99 +++++++++
 tb/tb_li_expander.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/li_expander.sv
// Load-immediate expander: turns a 32-bit constant load request into one or
// two MIPS I-type words (ADDI/ADDIU, LUI, or LUI followed by ORI).
module li_expander #(
  parameter int USE_ADDIU = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT_ONE,
    EMIT_HI,
    EMIT_LO
  } state_t;

  localparam logic [5:0] OP_SHORT = (USE_ADDIU != 0) ? 6'h09 : 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ori_q, ori_d;

  logic        short_fit;
  logic        lo_zero;
  logic [31:0] short_w;
  logic [31:0] lui_w;
  logic [31:0] ori_w;

  // Short form fits when the upper 17 bits are a sign extension of bit 15.
  assign short_fit = (&in_value[31:15]) | ~(|in_value[31:15]);
  assign lo_zero   = ~(|in_value[15:0]);
  assign short_w   = {OP_SHORT, 5'd0, in_rt, in_value[15:0]};
  assign lui_w     = {OP_LUI, 5'd0, in_rt, in_value[31:16]};
  assign ori_w     = {OP_ORI, in_rt, in_rt, in_value[15:0]};

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ori_d   = ori_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          ori_d = ori_w;
          if (short_fit) begin
            state_d = EMIT_ONE;
            instr_d = short_w;
          end else if (lo_zero) begin
            state_d = EMIT_ONE;
            instr_d = lui_w;
          end else begin
            state_d = EMIT_HI;
            instr_d = lui_w;
          end
        end
      end
      EMIT_HI: begin
        if (out_ready) begin
          state_d = EMIT_LO;
          instr_d = ori_q;
        end
      end
      EMIT_ONE,
      EMIT_LO: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      instr_q <= 32'h0;
      ori_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ori_q   <= ori_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign out_last  = (state_q == EMIT_ONE) || (state_q == EMIT_LO);
  assign out_instr = instr_q;

endmodule

// File: tb/tb_li_expander.sv
// Scoreboard bench for li_expander: ADDI and ADDIU instances share stimulus,
// expected words are queued at accept and checked by a separate monitor.
module tb_li_expander;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_value;
  logic [4:0]  in_rt;
  logic        out_ready = 1'b0;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [31:0] out_instr0, out_instr1;
  logic        out_last0, out_last1;

  always #5 clk = ~clk;

  li_expander #(.USE_ADDIU(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_value(in_value), .in_rt(in_rt),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_instr(out_instr0), .out_last(out_last0)
  );

  li_expander #(.USE_ADDIU(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_value(in_value), .in_rt(in_rt),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_instr(out_instr1), .out_last(out_last1)
  );

  typedef struct {
    logic [31:0] w;
    logic [31:0] wu;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] v;
    logic [4:0]  rt;
    int          n;
    logic [31:0] w0;
    logic [31:0] w0u;
    logic [31:0] w1;
  } dir_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   acc_now = 0;
  int   rmode   = 1;
  bit   man_ready = 1;

  dir_t dirs[4] = '{
    '{32'h00002AAA, 5'd8,  1, 32'h20082AAA, 32'h24082AAA, 32'h0},
    '{32'hFFFF9999, 5'd9,  1, 32'h20099999, 32'h24099999, 32'h0},
    '{32'h00008000, 5'd2,  2, 32'h3C020000, 32'h3C020000, 32'h34428000},
    '{32'h12340000, 5'd31, 1, 32'h3C1F1234, 32'h3C1F1234, 32'h0}
  };

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] wu,
                      input logic last);
    exp_t e;
    e.w = w;
    e.wu = wu;
    e.last = last;
    q.push_back(e);
  endtask

  // Reference: choose encoding by the numeric range of the constant.
  task automatic push_model(input logic [31:0] v, input logic [4:0] rt);
    longint sv;
    logic [31:0] lui;
    sv = longint'($signed(v));
    lui = {6'h0F, 5'd0, rt, v[31:16]};
    if (sv >= -32768 && sv <= 32767) begin
      push({6'h08, 5'd0, rt, v[15:0]}, {6'h09, 5'd0, rt, v[15:0]}, 1'b1);
    end else if (v[15:0] == 16'h0) begin
      push(lui, lui, 1'b1);
    end else begin
      push(lui, lui, 1'b0);
      push({6'h0D, rt, rt, v[15:0]}, {6'h0D, rt, rt, v[15:0]}, 1'b1);
    end
  endtask

  task automatic push_dir(input int i);
    if (dirs[i].n == 1) begin
      push(dirs[i].w0, dirs[i].w0u, 1'b1);
    end else begin
      push(dirs[i].w0, dirs[i].w0u, 1'b0);
      push(dirs[i].w1, dirs[i].w1, 1'b1);
    end
  endtask

  task automatic send(input logic [31:0] v, input logic [4:0] rt,
                      input bit keep, input int di);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    in_rt = rt;
    forever begin
      #2;
      if (in_ready0) begin
        acc_now = 1;
        if (di < 0) push_model(v, rt);
        else push_dir(di);
        break;
      end
      t++;
      if (t > 100) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    acc_now = 0;
    in_valid = keep;
    in_value = $urandom;
    in_rt = 5'($urandom);
  endtask

  task automatic wait_q(input int n);
    int t = 0;
    while (q.size() > n) begin
      @(negedge clk);
      #4;
      t++;
      if (t > 500) begin
        chk("drain_timeout", 32'(q.size()), 32'(n));
        q.delete();
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      case (rmode)
        0: out_ready = ($urandom_range(0, 3) != 0);
        1: out_ready = 1'b1;
        default: out_ready = man_ready;
      endcase
    end
  end

  // Monitor: compares whatever the DUTs present against the queue head.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      #3;
      if (reset_n) begin
        ev = (q.size() > 0) && !acc_now;
        chk("out_valid", 32'(out_valid0), 32'(ev));
        chk("out_valid_addiu", 32'(out_valid1), 32'(ev));
        chk("in_ready", 32'(in_ready0), 32'(!ev));
        if (ev && out_valid0) begin
          chk("out_instr", out_instr0, q[0].w);
          chk("out_instr_addiu", out_instr1, q[0].wu);
          chk("out_last", 32'(out_last0), 32'(q[0].last));
          if (out_ready) void'(q.pop_front());
        end else if (!ev) begin
          chk("out_last_idle", 32'(out_last0), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    int k;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_value = 32'h0;
    in_rt = 5'd0;
    #1;
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_instr", out_instr0, 32'h0);
    chk("rst_out_last", 32'(out_last0), 32'd0);
    repeat (2) @(negedge clk);
    #4;
    reset_n = 1'b1;

    rmode = 1;
    for (int i = 0; i < 4; i++) send(dirs[i].v, dirs[i].rt, 1'b0, i);
    wait_q(0);

    rmode = 2;
    man_ready = 1'b1;
    send(dirs[2].v, dirs[2].rt, 1'b0, 2);
    wait_q(1);
    man_ready = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    man_ready = 1'b1;
    wait_q(0);
    repeat (3) @(negedge clk);

    send(dirs[2].v, dirs[2].rt, 1'b0, 2);
    wait_q(1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid0), 32'd0);
    chk("midrst_in_ready", 32'(in_ready0), 32'd1);
    chk("midrst_out_instr", out_instr0, 32'h0);
    chk("midrst_out_last", 32'(out_last0), 32'd0);
    q.delete();
    @(negedge clk);
    #4;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    rmode = 0;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: v = {{16{1'b0}}, 16'($urandom)} | 32'h0;
        1: v = {{17{1'b1}}, 15'($urandom)};
        2: v = {16'($urandom), 16'h0};
        3: begin
          case ($urandom_range(0, 5))
            0: v = 32'h00007FFF;
            1: v = 32'h00008000;
            2: v = 32'hFFFF8000;
            3: v = 32'hFFFF7FFF;
            4: v = 32'h00000000;
            default: v = 32'hFFFFFFFF;
          endcase
        end
        default: v = $urandom;
      endcase
      send(v, 5'($urandom), bit'($urandom_range(0, 1)), -1);
    end
    in_valid = 1'b0;
    wait_q(0);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
